// File: rtl/result_checker_if.sv
// Bundle between result_checker and its surroundings: run control, BRAM/ROM read port
// and the graded results. The checker takes the master side.
interface result_checker_if #(
    parameter int unsigned AddrWL = 11,
    parameter int unsigned DataWL = 18
);
    logic              start;
    logic [AddrWL:0]   len;
    logic              bram_read_en;
    logic [AddrWL-1:0] bram_address_read;
    logic [DataWL-1:0] bram_dout;
    logic [DataWL-1:0] golden_dout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [AddrWL:0]   err_count;
    logic [AddrWL-1:0] first_err_addr;
    logic              first_err_valid;
    logic [DataWL-1:0] err_mask;

    modport master (
        input  start, len, bram_dout, golden_dout,
        output bram_read_en, bram_address_read, busy, done, pass,
               err_count, first_err_addr, first_err_valid, err_mask
    );

    modport slave (
        output start, len, bram_dout, golden_dout,
        input  bram_read_en, bram_address_read, busy, done, pass,
               err_count, first_err_addr, first_err_valid, err_mask
    );
endinterface

// File: rtl/result_checker.sv
// Reads back a captured result run from the BRAM, compares each word with the golden
// ROM and reports mismatch count, first failing address and a sticky failing-bit mask.
module result_checker #(
    parameter int unsigned AddrWL = 11,
    parameter int unsigned DataWL = 18
) (
    input logic                clk,
    input logic                sys_rst,
    result_checker_if.master   bus
);

    localparam logic [AddrWL:0]   MaxLen  = {1'b1, {AddrWL{1'b0}}};
    localparam logic [AddrWL:0]   CntMax  = '1;
    localparam logic [AddrWL:0]   CntOne  = {{AddrWL{1'b0}}, 1'b1};
    localparam logic [AddrWL-1:0] AddrOne = {{(AddrWL-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q;
    logic              read_en_q;
    logic [AddrWL-1:0] addr_q;
    logic [AddrWL-1:0] last_addr_q;
    logic              tag_valid_q;
    logic [AddrWL-1:0] tag_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [AddrWL:0]   err_count_q;
    logic [AddrWL-1:0] first_err_addr_q;
    logic              first_err_valid_q;
    logic [DataWL-1:0] err_mask_q;

    logic [AddrWL:0]   len_clamped;
    logic [DataWL-1:0] diff;
    logic              mismatch;
    logic [AddrWL:0]   count_next;

    always_comb begin
        len_clamped = (bus.len > MaxLen) ? MaxLen : bus.len;
        diff        = bus.bram_dout ^ bus.golden_dout;
        mismatch    = tag_valid_q && (bus.bram_dout != bus.golden_dout);
        count_next  = (err_count_q == CntMax) ? err_count_q : err_count_q + CntOne;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q           <= StIdle;
            read_en_q         <= 1'b0;
            addr_q            <= '0;
            last_addr_q       <= '0;
            tag_valid_q       <= 1'b0;
            tag_addr_q        <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b1;
            err_count_q       <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
            err_mask_q        <= '0;
        end else begin
            // Tag follows the read by one cycle, matching the BRAM/ROM read latency.
            tag_valid_q <= read_en_q;
            tag_addr_q  <= addr_q;
            done_q      <= 1'b0;

            if (mismatch) begin
                err_count_q <= count_next;
                err_mask_q  <= err_mask_q | diff;
                pass_q      <= 1'b0;
                if (!first_err_valid_q) begin
                    first_err_addr_q  <= tag_addr_q;
                    first_err_valid_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q            <= 1'b1;
                        err_count_q       <= '0;
                        err_mask_q        <= '0;
                        first_err_valid_q <= 1'b0;
                        pass_q            <= 1'b1;
                        last_addr_q       <= len_clamped[AddrWL-1:0] - AddrOne;
                        if (len_clamped == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= StRead;
                            read_en_q <= 1'b1;
                            addr_q    <= '0;
                        end
                    end
                end
                StRead: begin
                    if (addr_q == last_addr_q) begin
                        read_en_q <= 1'b0;
                        state_q   <= StDrain;
                    end else begin
                        addr_q <= addr_q + AddrOne;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.bram_read_en      = read_en_q;
    assign bus.bram_address_read = addr_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.pass              = pass_q;
    assign bus.err_count         = err_count_q;
    assign bus.first_err_addr    = first_err_addr_q;
    assign bus.first_err_valid   = first_err_valid_q;
    assign bus.err_mask          = err_mask_q;

endmodule
